datapath_run_ctrl: RTL
======================

DATAPATH_RUN_CTRL -- requirements
Module: datapath_run_ctrl

Interface
REQ-001 The block SHALL have a single clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Ports SHALL be:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  host command present
- cmd_op  in  2  00 NOP, 01 RUN, 10 STEP, 11 HALT
- step_count  in  16  STEP length in instructions
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- bp_en  in  1  breakpoint enable
- bp_addr  in  64  breakpoint PC
- pc  in  64  current datapath PC
- instr  in  32  instruction at pc
- cpu_en  out  1  datapath commits one instruction on this edge when high
- halted  out  1  high in HALTED state
- halt_cause  out  3  000 RESET, 001 CMD, 010 STEP_DONE, 011 BREAKPOINT, 100 EBREAK
- retired  out  64  instructions committed since reset

Function
REQ-003 The FSM SHALL have exactly three states: HALTED, RUNNING, STEPPING.
REQ-004 cmd_ready SHALL be high in HALTED for any op, and high in RUNNING/STEPPING only when cmd_op=HALT; an accept is cmd_valid & cmd_ready.
REQ-005 HALTED + accepted RUN: RUNNING next cycle, skip flag set.
REQ-006 HALTED + accepted STEP: STEPPING next cycle, step counter loaded with step_count (0 treated as 1), skip flag set.
REQ-007 HALTED + accepted HALT or NOP: no state change, halt_cause unchanged.
REQ-008 The skip flag SHALL suppress the breakpoint check for the first cpu_en cycle after leaving HALTED, then clear.
REQ-009 cpu_en SHALL be combinational: high only in RUNNING/STEPPING, and low in any cycle with an accepted HALT, an unsuppressed breakpoint hit (bp_en & pc==bp_addr), or instr==32'h00100073 (EBREAK).
REQ-010 A cycle in which cpu_en is forced low in RUNNING/STEPPING SHALL move to HALTED next cycle with cause priority EBREAK > BREAKPOINT > CMD.
REQ-011 In STEPPING, each cpu_en cycle SHALL decrement the step counter; the cycle committing the last instruction SHALL move to HALTED with cause STEP_DONE.
REQ-012 An EBREAK is never committed; RUN at an EBREAK pc SHALL halt again on the first cycle with cause EBREAK.
REQ-013 retired SHALL increment by 1 on every cycle with cpu_en high and wrap from 2^64-1 to 0.
REQ-014 halted and halt_cause SHALL be registered; cpu_en and cmd_ready are the only combinational outputs.

Reset
REQ-015 On reset the block SHALL enter HALTED with halted=1, halt_cause=RESET, retired=0, step counter=0, skip=0, and cpu_en=0 in the reset cycle.
REQ-016 Reset asserted during RUNNING/STEPPING SHALL override any command or halt event in that cycle.

Structure
REQ-017 A shared package cpu_ctrl_pkg SHALL hold the state encoding, cmd_op codes, halt_cause codes and the EBREAK constant.
REQ-018 The block SHALL be a single module with no sub-modules; the step counter, skip flag and retire counter are inline registers.

Verification
REQ-019 Reset, then RUN with bp_en=0 for 10 cycles, then HALT -> retired=10, halted=1, halt_cause=001.
REQ-020 STEP step_count=3 -> cpu_en high for exactly 3 cycles, halt_cause=010, retired+3; STEP step_count=0 -> exactly 1 instruction committed.
REQ-021 bp_en=1, bp_addr=0x20, RUN from pc=0 -> halt with pc=0x20, cpu_en=0 at 0x20, halt_cause=011; RUN again -> 0x20 committed, no re-halt until the next hit.
REQ-022 instr=0x00100073 while RUNNING -> cpu_en=0 that cycle, halt_cause=100, retired unchanged; RUN again -> immediate re-halt.
REQ-023 HALT and breakpoint hit in the same cycle -> halt_cause=011; RUN/STEP issued while RUNNING -> cmd_ready=0, state unchanged.
REQ-024 reset asserted mid-STEP with step_count=5 -> next cycle halted=1, halt_cause=000, retired=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the datapath run controller: FSM state encoding,
// host command opcodes, halt cause codes and the EBREAK instruction word.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [2:0] CAUSE_RESET      = 3'b000;
  localparam logic [2:0] CAUSE_CMD        = 3'b001;
  localparam logic [2:0] CAUSE_STEP_DONE  = 3'b010;
  localparam logic [2:0] CAUSE_BREAKPOINT = 3'b011;
  localparam logic [2:0] CAUSE_EBREAK     = 3'b100;

  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

endpackage

// File: rtl/datapath_run_ctrl.sv
// Run/step/halt controller gating datapath commits, with PC breakpoint,
// EBREAK detection and a free-running retired-instruction counter.
module datapath_run_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] step_count,
  output logic        cmd_ready,
  input  logic        bp_en,
  input  logic [63:0] bp_addr,
  input  logic [63:0] pc,
  input  logic [31:0] instr,
  output logic        cpu_en,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [63:0] retired
);

  state_t      state, state_next;
  logic [15:0] step_cnt, step_next;
  logic        skip, skip_next;
  logic [2:0]  cause_next;

  logic in_active;
  logic accept;
  logic halt_cmd;
  logic bp_hit;
  logic is_ebreak;

  assign in_active = (state != ST_HALTED);
  assign cmd_ready = !in_active || (cmd_op == OP_HALT);
  assign accept    = cmd_valid && cmd_ready;
  assign halt_cmd  = in_active && accept && (cmd_op == OP_HALT);
  // The skip flag lets the host resume from the very PC that just hit the breakpoint
  assign bp_hit    = bp_en && (pc == bp_addr) && !skip;
  assign is_ebreak = (instr == EBREAK_INSTR);
  assign cpu_en    = in_active && !reset && !halt_cmd && !bp_hit && !is_ebreak;

  always_comb begin
    state_next = state;
    step_next  = step_cnt;
    skip_next  = skip;
    cause_next = halt_cause;
    case (state)
      ST_HALTED: begin
        if (accept && cmd_op == OP_RUN) begin
          state_next = ST_RUNNING;
          skip_next  = 1'b1;
        end else if (accept && cmd_op == OP_STEP) begin
          state_next = ST_STEPPING;
          skip_next  = 1'b1;
          step_next  = (step_count == 16'd0) ? 16'd1 : step_count;
        end
      end
      ST_RUNNING, ST_STEPPING: begin
        if (!cpu_en) begin
          state_next = ST_HALTED;
          if (is_ebreak)   cause_next = CAUSE_EBREAK;
          else if (bp_hit) cause_next = CAUSE_BREAKPOINT;
          else             cause_next = CAUSE_CMD;
        end else begin
          skip_next = 1'b0;
          if (state == ST_STEPPING) begin
            step_next = step_cnt - 16'd1;
            if (step_cnt <= 16'd1) begin
              state_next = ST_HALTED;
              cause_next = CAUSE_STEP_DONE;
            end
          end
        end
      end
      default: state_next = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HALTED;
      halted     <= 1'b1;
      halt_cause <= CAUSE_RESET;
      retired    <= 64'd0;
      step_cnt   <= 16'd0;
      skip       <= 1'b0;
    end else begin
      state      <= state_next;
      halted     <= (state_next == ST_HALTED);
      halt_cause <= cause_next;
      step_cnt   <= step_next;
      skip       <= skip_next;
      if (cpu_en) retired <= retired + 64'd1;
    end
  end

endmodule
